// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the shared-ALU sequencer: op codes, legality check, FSM states.
package alu_ctrl_pkg;

    localparam int unsigned ALU_CTRL_W = 6;

    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 6'h00;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 6'h01;
    localparam logic [ALU_CTRL_W-1:0] ALU_AND = 6'h02;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 6'h03;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 6'h05;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } alu_state_e;

    // Full control word is compared, so a set upper bit makes the op illegal.
    function automatic logic alu_op_legal(input logic [ALU_CTRL_W-1:0] ctrl);
        case (ctrl)
            ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT: return 1'b1;
            default:                                    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_share_ctrl_rr_arb2.sv
// Two-input round-robin arbiter; ties go to the requester that did not win last.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update_en,
    output logic [1:0] gnt_c
);

    logic last_grant_q;
    logic last_grant_d;

    // Grant decode and last-grant update.
    always_comb begin
        gnt_c        = 2'b00;
        last_grant_d = last_grant_q;
        case (req)
            2'b01:   gnt_c = 2'b01;
            2'b10:   gnt_c = 2'b10;
            2'b11:   gnt_c = last_grant_q ? 2'b01 : 2'b10;
            default: gnt_c = 2'b00;
        endcase
        if (update_en) begin
            last_grant_d = gnt_c[1];
        end
    end

    // Reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one single-cycle ALU between two requesters, one operation in flight.
module alu_share_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned CTRL_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [CTRL_W-1:0] req0_ctrl,
    input  logic [WIDTH-1:0]  req0_a,
    input  logic [WIDTH-1:0]  req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [CTRL_W-1:0] req1_ctrl,
    input  logic [WIDTH-1:0]  req1_a,
    input  logic [WIDTH-1:0]  req1_b,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [WIDTH-1:0]  rsp0_result,
    output logic              rsp0_zero,
    output logic              rsp0_err,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [WIDTH-1:0]  rsp1_result,
    output logic              rsp1_zero,
    output logic              rsp1_err,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [WIDTH-1:0]  alu_result,
    input  logic              alu_zero
);

    alu_state_e             state_q, state_d;
    logic                   owner_q, owner_d;
    logic [WIDTH-1:0]       alu_a_q, alu_a_d;
    logic [WIDTH-1:0]       alu_b_q, alu_b_d;
    logic [CTRL_W-1:0]      alu_ctrl_q, alu_ctrl_d;
    logic [1:0]             rsp_valid_q, rsp_valid_d;
    logic [1:0][WIDTH-1:0]  rsp_result_q, rsp_result_d;
    logic [1:0]             rsp_zero_q, rsp_zero_d;
    logic [1:0]             rsp_err_q, rsp_err_d;

    logic [1:0] gnt_c;
    logic [1:0] rsp_ready_c;
    logic       idle_c;
    logic       accept_c;
    logic       legal_c;

    assign idle_c      = (state_q == IDLE);
    assign accept_c    = idle_c && (req0_valid || req1_valid);
    assign rsp_ready_c = {rsp1_ready, rsp0_ready};
    assign legal_c     = alu_op_legal(ALU_CTRL_W'(alu_ctrl_q));

    rr_arb2 u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       ({req1_valid, req0_valid}),
        .update_en (accept_c),
        .gnt_c     (gnt_c)
    );

    // Ready is only offered in IDLE, to the arbiter's winner.
    assign req0_ready = idle_c && gnt_c[0];
    assign req1_ready = idle_c && gnt_c[1];

    // Next-state and datapath capture for the IDLE -> EXEC -> RESP sequence.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_ctrl_d   = alu_ctrl_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    owner_d    = gnt_c[1];
                    alu_ctrl_d = gnt_c[1] ? req1_ctrl : req0_ctrl;
                    alu_a_d    = gnt_c[1] ? req1_a    : req0_a;
                    alu_b_d    = gnt_c[1] ? req1_b    : req0_b;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                rsp_result_d[owner_q] = legal_c ? alu_result : '0;
                rsp_zero_d[owner_q]   = legal_c && alu_zero;
                rsp_err_d[owner_q]    = !legal_c;
                rsp_valid_d[owner_q]  = 1'b1;
                state_d               = RESP;
            end
            RESP: begin
                if (rsp_valid_q[owner_q] && rsp_ready_c[owner_q]) begin
                    rsp_valid_d[owner_q] = 1'b0;
                    state_d              = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset discards any in-flight operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_ctrl_q   <= '0;
            rsp_valid_q  <= '0;
            rsp_result_q <= '0;
            rsp_zero_q   <= '0;
            rsp_err_q    <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_ctrl_q   <= alu_ctrl_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_ctrl    = alu_ctrl_q;
    assign rsp0_valid  = rsp_valid_q[0];
    assign rsp0_result = rsp_result_q[0];
    assign rsp0_zero   = rsp_zero_q[0];
    assign rsp0_err    = rsp_err_q[0];
    assign rsp1_valid  = rsp_valid_q[1];
    assign rsp1_result = rsp_result_q[1];
    assign rsp1_zero   = rsp_zero_q[1];
    assign rsp1_err    = rsp_err_q[1];

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a response scoreboard and a stand-in ALU.
module tb_alu_share_ctrl;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned CTRL_W = 6;

    logic              clk = 1'b0;
    logic              reset;
    logic              req0_valid, req0_ready;
    logic [CTRL_W-1:0] req0_ctrl;
    logic [WIDTH-1:0]  req0_a, req0_b;
    logic              req1_valid, req1_ready;
    logic [CTRL_W-1:0] req1_ctrl;
    logic [WIDTH-1:0]  req1_a, req1_b;
    logic              rsp0_valid, rsp0_ready, rsp0_zero, rsp0_err;
    logic [WIDTH-1:0]  rsp0_result;
    logic              rsp1_valid, rsp1_ready, rsp1_zero, rsp1_err;
    logic [WIDTH-1:0]  rsp1_result;
    logic [WIDTH-1:0]  alu_a, alu_b, alu_result;
    logic [CTRL_W-1:0] alu_ctrl;
    logic              alu_zero;

    int vectors     = 0;
    int miscompares = 0;

    logic [33:0] exp_q0[$];
    logic [33:0] exp_q1[$];
    logic [33:0] sb_e;

    always #5 clk = ~clk;

    alu_share_ctrl #(.WIDTH(WIDTH), .CTRL_W(CTRL_W)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctrl(req0_ctrl),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctrl(req1_ctrl),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
        .rsp0_zero(rsp0_zero), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
        .rsp1_zero(rsp1_zero), .rsp1_err(rsp1_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_zero(alu_zero)
    );

    // Stand-in ALU; illegal codes produce garbage that the DUT must ignore.
    always_comb begin
        alu_result = '0;
        alu_zero   = 1'b0;
        case (alu_ctrl)
            6'h00: alu_result = alu_a + alu_b;
            6'h01: alu_result = alu_a - alu_b;
            6'h02: alu_result = alu_a & alu_b;
            6'h03: alu_result = alu_a | alu_b;
            6'h05: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            default: alu_result = 32'hDEAD_BEEF;
        endcase
        alu_zero = (alu_result == '0) || (alu_result == 32'hDEAD_BEEF);
    end

    // Expected {err, zero, result} for one request.
    function automatic logic [33:0] alu_model(input logic [5:0] c, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [31:0] r;
        logic        ok;
        r  = '0;
        ok = 1'b1;
        case (c)
            6'h00: r = a + b;
            6'h01: r = a - b;
            6'h02: r = a & b;
            6'h03: r = a | b;
            6'h05: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: ok = 1'b0;
        endcase
        if (!ok) return {1'b1, 1'b0, 32'd0};
        return {1'b0, (r == 32'd0), r};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: push on request handshake, pop on response handshake.
    always @(negedge clk) begin
        if (reset) begin
            exp_q0.delete();
            exp_q1.delete();
        end else begin
            if (req0_valid && req0_ready) exp_q0.push_back(alu_model(req0_ctrl, req0_a, req0_b));
            if (req1_valid && req1_ready) exp_q1.push_back(alu_model(req1_ctrl, req1_a, req1_b));
            if (rsp0_valid && rsp0_ready) begin
                if (exp_q0.size() == 0) begin
                    chk("sb_rsp0_unexpected", 64'(rsp0_valid), 64'd0);
                end else begin
                    sb_e = exp_q0.pop_front();
                    chk("sb_rsp0", 64'({rsp0_err, rsp0_zero, rsp0_result}), 64'(sb_e));
                end
            end
            if (rsp1_valid && rsp1_ready) begin
                if (exp_q1.size() == 0) begin
                    chk("sb_rsp1_unexpected", 64'(rsp1_valid), 64'd0);
                end else begin
                    sb_e = exp_q1.pop_front();
                    chk("sb_rsp1", 64'({rsp1_err, rsp1_zero, rsp1_result}), 64'(sb_e));
                end
            end
        end
    end

    // One isolated operation from requester n, entered at posedge+1 with the FSM in IDLE.
    task automatic do_op(input int n, input logic [5:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_r,
                         input logic exp_z, input logic exp_e);
        if (n == 0) begin
            req0_valid = 1'b1; req0_ctrl = c; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_ctrl = c; req1_a = a; req1_b = b;
        end
        @(negedge clk);
        chk("grant_ready", 64'((n == 0) ? req0_ready : req1_ready), 64'd1);
        chk("other_ready", 64'((n == 0) ? req1_ready : req0_ready), 64'd0);
        cyc();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        chk("exec_alu_ctrl", 64'(alu_ctrl), 64'(c));
        chk("exec_alu_a", 64'(alu_a), 64'(a));
        chk("exec_alu_b", 64'(alu_b), 64'(b));
        chk("exec_rsp_valid", 64'((n == 0) ? rsp0_valid : rsp1_valid), 64'd0);
        cyc();
        @(negedge clk);
        chk("rsp_valid", 64'((n == 0) ? rsp0_valid : rsp1_valid), 64'd1);
        chk("rsp_other_valid", 64'((n == 0) ? rsp1_valid : rsp0_valid), 64'd0);
        chk("rsp_result", 64'((n == 0) ? rsp0_result : rsp1_result), 64'(exp_r));
        chk("rsp_zero", 64'((n == 0) ? rsp0_zero : rsp1_zero), 64'(exp_z));
        chk("rsp_err", 64'((n == 0) ? rsp0_err : rsp1_err), 64'(exp_e));
        cyc();
    endtask

    initial begin
        reset = 1'b1;
        req0_valid = 1'b0; req0_ctrl = '0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_ctrl = '0; req1_a = '0; req1_b = '0;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;

        // Reset state.
        cyc();
        cyc();
        @(negedge clk);
        chk("rst_rsp0_valid", 64'(rsp0_valid), 64'd0);
        chk("rst_rsp1_valid", 64'(rsp1_valid), 64'd0);
        chk("rst_rsp0_fields", 64'({rsp0_err, rsp0_zero, rsp0_result}), 64'd0);
        chk("rst_rsp1_fields", 64'({rsp1_err, rsp1_zero, rsp1_result}), 64'd0);
        chk("rst_alu", 64'({alu_ctrl, alu_a}), 64'd0);
        chk("rst_alu_b", 64'(alu_b), 64'd0);
        cyc();
        reset = 1'b0;

        // Basic ops on each requester.
        do_op(0, 6'h00, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0);
        do_op(1, 6'h01, 32'd9, 32'd9, 32'd0, 1'b1, 1'b0);
        do_op(1, 6'h05, 32'd3, 32'd5, 32'd1, 1'b0, 1'b0);
        do_op(1, 6'h05, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b0, 1'b0);
        do_op(0, 6'h02, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F, 1'b0, 1'b0);

        // Illegal codes, including one with the upper control bit set.
        do_op(0, 6'h04, 32'd1, 32'd1, 32'd0, 1'b0, 1'b1);
        do_op(1, 6'h20, 32'd1, 32'd1, 32'd0, 1'b0, 1'b1);

        // Both valid after reset: grants alternate starting with requester 0.
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        req0_valid = 1'b1; req0_ctrl = 6'h00; req0_a = 32'd1; req0_b = 32'd1;
        req1_valid = 1'b1; req1_ctrl = 6'h03; req1_a = 32'd4; req1_b = 32'd2;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rr_ready0", 64'(req0_ready), 64'((k % 2) == 0));
            chk("rr_ready1", 64'(req1_ready), 64'((k % 2) == 1));
            cyc();
            @(negedge clk);
            chk("rr_exec_ready", 64'({req1_ready, req0_ready}), 64'd0);
            cyc();
            @(negedge clk);
            if ((k % 2) == 0) begin
                chk("rr_rsp0_valid", 64'({rsp1_valid, rsp0_valid}), 64'b01);
                chk("rr_rsp0_result", 64'(rsp0_result), 64'd2);
            end else begin
                chk("rr_rsp1_valid", 64'({rsp1_valid, rsp0_valid}), 64'b10);
                chk("rr_rsp1_result", 64'(rsp1_result), 64'd6);
            end
            cyc();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Backpressure on rsp0 while requester 1 waits.
        rsp0_ready = 1'b0;
        req0_valid = 1'b1; req0_ctrl = 6'h00; req0_a = 32'd10; req0_b = 32'd20;
        @(negedge clk);
        chk("bp_req0_ready", 64'(req0_ready), 64'd1);
        cyc();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_ctrl = 6'h03; req1_a = 32'd4; req1_b = 32'd2;
        @(negedge clk);
        chk("bp_exec_req1_ready", 64'(req1_ready), 64'd0);
        cyc();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("bp_rsp0_valid", 64'(rsp0_valid), 64'd1);
            chk("bp_rsp0_fields", 64'({rsp0_err, rsp0_zero, rsp0_result}), 64'd30);
            chk("bp_req1_ready", 64'(req1_ready), 64'd0);
            cyc();
        end
        rsp0_ready = 1'b1;
        @(negedge clk);
        chk("bp_hs_rsp0_valid", 64'(rsp0_valid), 64'd1);
        chk("bp_hs_req1_ready", 64'(req1_ready), 64'd0);
        cyc();
        @(negedge clk);
        chk("bp_after_rsp0_valid", 64'(rsp0_valid), 64'd0);
        chk("bp_after_req1_ready", 64'(req1_ready), 64'd1);
        cyc();
        req1_valid = 1'b0;
        cyc();
        @(negedge clk);
        chk("bp_rsp1_valid", 64'(rsp1_valid), 64'd1);
        chk("bp_rsp1_result", 64'(rsp1_result), 64'd6);
        cyc();

        // Reset during EXEC aborts the operation.
        req0_valid = 1'b1; req0_ctrl = 6'h01; req0_a = 32'd60; req0_b = 32'd50;
        @(negedge clk);
        chk("abort_req0_ready", 64'(req0_ready), 64'd1);
        cyc();
        req0_valid = 1'b0;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        @(negedge clk);
        chk("abort_rsp_valid", 64'({rsp1_valid, rsp0_valid}), 64'd0);
        chk("abort_alu_ctrl", 64'(alu_ctrl), 64'd0);
        chk("abort_alu_a", 64'(alu_a), 64'd0);
        for (int k = 0; k < 3; k++) begin
            cyc();
            @(negedge clk);
            chk("abort_no_rsp", 64'({rsp1_valid, rsp0_valid}), 64'd0);
        end
        cyc();
        do_op(0, 6'h00, 32'd100, 32'd23, 32'd123, 1'b0, 1'b0);

        // Every accepted request was answered.
        cyc();
        chk("sb_q0_drained", 64'(exp_q0.size()), 64'd0);
        chk("sb_q1_drained", 64'(exp_q1.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
